// File: rtl/exposure_sequencer.sv
// Camera exposure sequencer: shutter open/settle, timed exposure, shutter close/settle,
// then a handshake with the CCD readout engine. Timing is counted in ms ticks.
module exposure_sequencer #(
    parameter int unsigned TICK_DIV    = 50000,
    parameter int unsigned SETTLE_MS   = 200,
    parameter int unsigned ACK_TIMEOUT = 255,
    parameter logic [1:0]  MODE_READ   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic        dark,
    input  logic [23:0] exp_ms,
    input  logic        ccd_busy,
    output logic        shutter_open,
    output logic        ccd_toggle,
    output logic [1:0]  ccd_mode,
    output logic        busy,
    output logic        done,
    output logic        aborted,
    output logic [23:0] elapsed_ms
);

    localparam int unsigned PS_W  = (TICK_DIV    > 1) ? $clog2(TICK_DIV)    : 1;
    localparam int unsigned SET_W = (SETTLE_MS   > 1) ? $clog2(SETTLE_MS)   : 1;
    localparam int unsigned ACK_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(TICK_DIV - 1);
    localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_MS - 1);
    localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_OPEN_SETTLE  = 3'd1;
    localparam logic [2:0] ST_EXPOSE       = 3'd2;
    localparam logic [2:0] ST_CLOSE_SETTLE = 3'd3;
    localparam logic [2:0] ST_READ_START   = 3'd4;
    localparam logic [2:0] ST_READ_WAIT    = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [PS_W-1:0]  presc_q, presc_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [ACK_W-1:0] ack_q, ack_d;
    logic [23:0]      exp_q, exp_d;
    logic             dark_q, dark_d;
    logic             abort_path_q, abort_path_d;
    logic [23:0]      elapsed_q, elapsed_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;

    logic tick;
    logic settle_last;
    logic expose_last;

    assign tick        = (presc_q == PS_LAST);
    assign settle_last = tick && (settle_q == SET_LAST);
    // Compare ms count against the latched exposure so no exp_ms*TICK_DIV product is needed.
    assign expose_last = (exp_q == 24'd0) || (tick && (elapsed_q == exp_q - 24'd1));

    always_comb begin
        state_d      = state_q;
        presc_d      = tick ? '0 : presc_q + PS_W'(1);
        settle_d     = settle_q;
        ack_d        = ack_q;
        exp_d        = exp_q;
        dark_d       = dark_q;
        abort_path_d = abort_path_q;
        elapsed_d    = elapsed_q;
        done_d       = 1'b0;
        aborted_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    exp_d        = exp_ms;
                    dark_d       = dark;
                    abort_path_d = 1'b0;
                    state_d      = dark ? ST_EXPOSE : ST_OPEN_SETTLE;
                end
            end
            ST_OPEN_SETTLE: begin
                if (abort) begin
                    abort_path_d = 1'b1;
                    state_d      = ST_CLOSE_SETTLE;
                end else if (settle_last) begin
                    state_d = ST_EXPOSE;
                end else if (tick) begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (abort) begin
                    if (dark_q) begin
                        aborted_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        abort_path_d = 1'b1;
                        state_d      = ST_CLOSE_SETTLE;
                    end
                end else begin
                    if (tick && exp_q != 24'd0) begin
                        elapsed_d = elapsed_q + 24'd1;
                    end
                    if (expose_last) begin
                        state_d = dark_q ? ST_READ_START : ST_CLOSE_SETTLE;
                    end
                end
            end
            ST_CLOSE_SETTLE: begin
                if (settle_last) begin
                    if (abort_path_q) begin
                        aborted_d    = 1'b1;
                        abort_path_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        state_d = ST_READ_START;
                    end
                end else if (tick) begin
                    settle_d = settle_q + SET_W'(1);
                end
            end
            ST_READ_START: begin
                if (ccd_busy) begin
                    state_d = ST_READ_WAIT;
                end else if (ack_q == ACK_LAST) begin
                    aborted_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    ack_d = ack_q + ACK_W'(1);
                end
            end
            ST_READ_WAIT: begin
                if (!ccd_busy) begin
                    done_d  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Every state starts its timing from zero; the prescaler is parked while idle.
        if (state_d != state_q || state_q == ST_IDLE) begin
            presc_d  = '0;
            settle_d = '0;
            ack_d    = '0;
        end
        if (state_d == ST_EXPOSE && state_q != ST_EXPOSE) begin
            elapsed_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            settle_q     <= '0;
            ack_q        <= '0;
            exp_q        <= '0;
            dark_q       <= 1'b0;
            abort_path_q <= 1'b0;
            elapsed_q    <= '0;
            done_q       <= 1'b0;
            aborted_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            settle_q     <= settle_d;
            ack_q        <= ack_d;
            exp_q        <= exp_d;
            dark_q       <= dark_d;
            abort_path_q <= abort_path_d;
            elapsed_q    <= elapsed_d;
            done_q       <= done_d;
            aborted_q    <= aborted_d;
        end
    end

    // Outputs decode directly from the state register so reset closes the shutter at once.
    assign shutter_open = (state_q == ST_OPEN_SETTLE) || (state_q == ST_EXPOSE && !dark_q);
    assign ccd_toggle   = (state_q == ST_READ_START);
    assign ccd_mode     = (state_q == ST_READ_START || state_q == ST_READ_WAIT) ? MODE_READ : 2'b00;
    assign busy         = (state_q != ST_IDLE);
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign elapsed_ms   = elapsed_q;

endmodule

// File: tb/tb_exposure_sequencer.sv
// Bench for exposure_sequencer: phase/duration model compared every cycle, plus
// directed scenarios with hand-computed cycle counts.
module tb_exposure_sequencer;

    localparam int TD      = 4;
    localparam int SM      = 2;
    localparam int AT      = 8;
    localparam int SET_CYC = SM * TD;

    localparam int P_IDLE  = 0;
    localparam int P_OPEN  = 1;
    localparam int P_EXP   = 2;
    localparam int P_CLOSE = 3;
    localparam int P_RS    = 4;
    localparam int P_RW    = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        dark = 1'b0;
    logic [23:0] exp_ms = 24'd0;
    logic        ccd_busy = 1'b0;
    logic        shutter_open;
    logic        ccd_toggle;
    logic [1:0]  ccd_mode;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [23:0] elapsed_ms;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          m_ph = P_IDLE;
    int          m_t = 0;
    logic [23:0] m_exp = 24'd0;
    logic [23:0] m_el = 24'd0;
    logic        m_dark = 1'b0;
    logic        m_abp = 1'b0;
    logic        m_done = 1'b0;
    logic        m_ab = 1'b0;

    int shut_cnt = 0, tog_cnt = 0, done_cnt = 0, ab_cnt = 0;
    int last_shut = 0, last_tog_rise = 0, last_busy_rise = 0, last_ab = 0;
    logic prev_tog = 1'b0, prev_busy = 1'b0;
    int   rd_cnt = 0;
    logic rd_en = 1'b0;

    exposure_sequencer #(
        .TICK_DIV(TD), .SETTLE_MS(SM), .ACK_TIMEOUT(AT), .MODE_READ(2'b01)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .dark(dark),
        .exp_ms(exp_ms), .ccd_busy(ccd_busy), .shutter_open(shutter_open),
        .ccd_toggle(ccd_toggle), .ccd_mode(ccd_mode), .busy(busy), .done(done),
        .aborted(aborted), .elapsed_ms(elapsed_ms)
    );

    always #5 clk = ~clk;

    // Model: a phase plus the number of cycles spent in it; durations are products of ms and TD.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ph <= P_IDLE; m_t <= 0; m_exp <= 24'd0; m_el <= 24'd0;
            m_dark <= 1'b0; m_abp <= 1'b0; m_done <= 1'b0; m_ab <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_ab   <= 1'b0;
            m_t    <= m_t + 1;
            case (m_ph)
                P_IDLE: if (start) begin
                    m_exp <= exp_ms; m_dark <= dark; m_abp <= 1'b0; m_t <= 0;
                    m_ph  <= dark ? P_EXP : P_OPEN;
                end
                P_OPEN: if (abort) begin
                    m_ph <= P_CLOSE; m_abp <= 1'b1; m_t <= 0;
                end else if (m_t + 1 == SET_CYC) begin
                    m_ph <= P_EXP; m_t <= 0;
                end
                P_EXP: if (abort) begin
                    m_el <= 24'(m_t / TD); m_t <= 0;
                    if (m_dark) begin m_ph <= P_IDLE; m_ab <= 1'b1; end
                    else begin m_ph <= P_CLOSE; m_abp <= 1'b1; end
                end else if (m_exp == 24'd0 || longint'(m_t) + 1 == longint'(m_exp) * TD) begin
                    m_el <= m_exp; m_t <= 0;
                    m_ph <= m_dark ? P_RS : P_CLOSE;
                end
                P_CLOSE: if (m_t + 1 == SET_CYC) begin
                    m_t <= 0;
                    if (m_abp) begin m_ph <= P_IDLE; m_ab <= 1'b1; m_abp <= 1'b0; end
                    else m_ph <= P_RS;
                end
                P_RS: if (ccd_busy) begin
                    m_ph <= P_RW; m_t <= 0;
                end else if (m_t + 1 == AT) begin
                    m_ph <= P_IDLE; m_ab <= 1'b1; m_t <= 0;
                end
                P_RW: if (!ccd_busy) begin
                    m_ph <= P_IDLE; m_done <= 1'b1; m_t <= 0;
                end
                default: m_ph <= P_IDLE;
            endcase
        end
    end

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // One clock step: compare against the model at the falling edge, update the
    // event monitor and the readout-engine model, then return 1ns later.
    task automatic tick();
        logic        e_shut, e_tog, e_busy;
        logic [1:0]  e_mode;
        logic [23:0] e_el;
        @(negedge clk);
        cyc++;
        e_shut = (m_ph == P_OPEN) || (m_ph == P_EXP && !m_dark);
        e_tog  = (m_ph == P_RS);
        e_mode = (m_ph == P_RS || m_ph == P_RW) ? 2'b01 : 2'b00;
        e_busy = (m_ph != P_IDLE);
        e_el   = (m_ph == P_EXP) ? 24'(m_t / TD) : m_el;
        chk("shutter_open", shutter_open, e_shut);
        chk("ccd_toggle", ccd_toggle, e_tog);
        chk("ccd_mode", ccd_mode, e_mode);
        chk("busy", busy, e_busy);
        chk("done", done, m_done);
        chk("aborted", aborted, m_ab);
        chk("elapsed_ms", elapsed_ms, e_el);
        if (shutter_open) begin shut_cnt++; last_shut = cyc; end
        if (ccd_toggle) tog_cnt++;
        if (ccd_toggle && !prev_tog) last_tog_rise = cyc;
        if (busy && !prev_busy) last_busy_rise = cyc;
        if (done) done_cnt++;
        if (aborted) begin ab_cnt++; last_ab = cyc; end
        prev_tog  = ccd_toggle;
        prev_busy = busy;
        if (rd_cnt == 0) begin
            if (rd_en && ccd_toggle) rd_cnt = 1;
        end else begin
            rd_cnt++;
        end
        if (rd_cnt >= 13) rd_cnt = 0;
        ccd_busy = (rd_cnt >= 3);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pulse_start(input logic d, input logic [23:0] e);
        start = 1'b1; dark = d; exp_ms = e;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_end(input string nm, input int budget);
        int   n;
        logic seen;
        n = 0; seen = 1'b0;
        while (!seen && n < budget) begin
            tick();
            n++;
            seen = done | aborted;
        end
        chk(nm, seen, 1);
    endtask

    initial begin
        int s_sh, s_tg, s_dn, s_ab, a, c;

        #2 rst = 1'b1;
        ticks(2);
        chk("reset_shutter", shutter_open, 0);
        chk("reset_busy", busy, 0);
        chk("reset_elapsed", elapsed_ms, 0);
        chk("reset_mode", ccd_mode, 0);
        rst = 1'b0;
        ticks(2);

        // Light frame, exp 3 ms
        rd_en = 1'b1;
        s_sh = shut_cnt; s_dn = done_cnt; s_ab = ab_cnt;
        pulse_start(1'b0, 24'd3);
        wait_end("light_end", 200);
        chk("light_shutter_cycles", shut_cnt - s_sh, 20);
        chk("light_closed_gap", last_tog_rise - last_shut - 1, 8);
        chk("light_elapsed", elapsed_ms, 3);
        ticks(4);
        chk("light_done_count", done_cnt - s_dn, 1);
        chk("light_aborted_count", ab_cnt - s_ab, 0);
        chk("light_idle", busy, 0);

        // Dark frame, exp 2 ms
        s_sh = shut_cnt; s_dn = done_cnt;
        pulse_start(1'b1, 24'd2);
        wait_end("dark_end", 200);
        chk("dark_toggle_delay", last_tog_rise - last_busy_rise, 8);
        chk("dark_shutter_cycles", shut_cnt - s_sh, 0);
        chk("dark_elapsed", elapsed_ms, 2);
        ticks(4);
        chk("dark_done_count", done_cnt - s_dn, 1);

        // Abort during exposure once elapsed_ms reaches 1; abort held into CLOSE_SETTLE
        s_tg = tog_cnt; s_ab = ab_cnt; s_dn = done_cnt;
        pulse_start(1'b0, 24'd5);
        for (int i = 0; i < 40 && elapsed_ms != 24'd1; i++) tick();
        chk("abort_reached_elapsed1", elapsed_ms, 1);
        abort = 1'b1; a = cyc;
        tick();
        chk("abort_shutter_fall", shutter_open, 0);
        ticks(2);
        abort = 1'b0;
        wait_end("abort_end", 50);
        chk("abort_idle_delay", last_ab - a, 9);
        chk("abort_elapsed_hold", elapsed_ms, 1);
        ticks(4);
        chk("abort_toggle_count", tog_cnt - s_tg, 0);
        chk("abort_aborted_count", ab_cnt - s_ab, 1);
        chk("abort_done_count", done_cnt - s_dn, 0);

        // Readout engine never answers
        rd_en = 1'b0;
        s_tg = tog_cnt; s_ab = ab_cnt;
        pulse_start(1'b1, 24'd1);
        wait_end("timeout_end", 100);
        chk("timeout_toggle_cycles", tog_cnt - s_tg, 8);
        ticks(3);
        chk("timeout_aborted_count", ab_cnt - s_ab, 1);
        chk("timeout_idle", busy, 0);

        // Dark abort in EXPOSE goes straight to IDLE
        s_ab = ab_cnt; s_tg = tog_cnt;
        pulse_start(1'b1, 24'd3);
        ticks(2);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("dark_abort_pulse", aborted, 1);
        ticks(5);
        chk("dark_abort_count", ab_cnt - s_ab, 1);
        chk("dark_abort_toggle", tog_cnt - s_tg, 0);

        // Abort on the final EXPOSE cycle wins over completion
        s_ab = ab_cnt; s_tg = tog_cnt;
        pulse_start(1'b1, 24'd1);
        ticks(3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        ticks(5);
        chk("coincide_aborted", ab_cnt - s_ab, 1);
        chk("coincide_toggle", tog_cnt - s_tg, 0);

        // exp_ms = 0 with a second start during the one-cycle EXPOSE
        rd_en = 1'b1;
        s_sh = shut_cnt; s_dn = done_cnt;
        pulse_start(1'b0, 24'd0);
        ticks(8);
        pulse_start(1'b1, 24'd7);
        dark = 1'b0;
        wait_end("exp0_end", 200);
        chk("exp0_shutter_cycles", shut_cnt - s_sh, 9);
        chk("exp0_elapsed", elapsed_ms, 0);
        ticks(10);
        chk("exp0_done_count", done_cnt - s_dn, 1);
        chk("exp0_idle", busy, 0);

        // Asynchronous reset while the shutter settles open
        pulse_start(1'b0, 24'd3);
        ticks(3);
        chk("pre_reset_shutter", shutter_open, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_reset_shutter", shutter_open, 0);
        chk("async_reset_busy", busy, 0);
        ticks(2);
        rst = 1'b0;
        s_tg = tog_cnt;
        ticks(40);
        chk("post_reset_toggle", tog_cnt - s_tg, 0);
        chk("post_reset_busy", busy, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
